dm_store_buffer: RTL and testbench

Posted-write store buffer between the pipeline's MEM-stage data-memory port and a slower, handshaked data memory. Stores from the MEM stage are queued in a small FIFO and retire in the background. Loads stall the pipeline only when they must reach memory. Loads drain all older stores before reading, so memory order is preserved; an optional forwarding path serves loads directly from buffered stores.

---
 rtl/dm_store_buffer.sv | 131 +++++++++++++
 tb/tb_dm_store_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store FIFO between the MEM stage and a handshaked data memory.
// Define DM_STORE_BUFFER_FWD_EN to let loads that hit a buffered store complete without stalling.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_dm_r,
    input  logic        cpu_dm_w,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_w_data,
    output logic [31:0] cpu_r_data,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_r_data,
    output logic        buf_empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD      = 2'd1;
    localparam logic [1:0] RD_DONE = 2'd2;

    logic [1:0]    state_q;
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW:0]   count_q;
    logic [29:0]   addr_buf [DEPTH];
    logic [31:0]   data_buf [DEPTH];
    logic [31:0]   rd_addr_q;
    logic [31:0]   rd_data_q;

    logic        drain;
    logic        rd_issue;
    logic        push;
    logic        pop;
    logic        is_load;
    logic        hit;
    logic        load_miss;
    logic [31:0] fwd_data;
    logic        unused_addr_lsb;

    assign drain     = (count_q != '0);
    assign rd_issue  = (state_q == RD) && !drain;
    assign pop       = drain && mem_ack;
    // Full test deliberately ignores a same-cycle pop so the accept path never depends on mem_ack.
    assign push      = (state_q == IDLE) && cpu_dm_w && (count_q < FULL_CNT);
    assign is_load   = (state_q == IDLE) && cpu_dm_r && !cpu_dm_w;
    assign load_miss = is_load && !hit;

`ifdef DM_STORE_BUFFER_FWD_EN
    // Walk oldest to youngest so the last match left standing is the youngest store.
    always_comb begin
        logic [AW-1:0] idx;
        logic          match;
        idx      = head_q;
        match    = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (((AW+1)'(i) < count_q) && (addr_buf[idx] == cpu_addr[31:2])) begin
                match    = 1'b1;
                fwd_data = data_buf[idx];
            end
        end
        hit = is_load && match;
    end
`else
    assign hit      = 1'b0;
    assign fwd_data = '0;
`endif

    assign mem_req    = drain || rd_issue;
    assign mem_we     = drain;
    assign mem_addr   = drain ? {addr_buf[head_q], 2'b00} : (rd_issue ? rd_addr_q : '0);
    assign mem_w_data = drain ? data_buf[head_q] : '0;
    assign buf_empty  = !drain;

    assign cpu_stall  = (state_q == RD) || load_miss || ((state_q == IDLE) && cpu_dm_w && !push);
    assign cpu_r_data = hit ? fwd_data : rd_data_q;

    assign unused_addr_lsb = ^cpu_addr[1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_buf[tail_q] <= cpu_addr[31:2];
            data_buf[tail_q] <= cpu_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
            if (push && !pop)
                count_q <= count_q + (AW+1)'(1);
            else if (pop && !push)
                count_q <= count_q - (AW+1)'(1);

            case (state_q)
                IDLE: begin
                    if (load_miss) begin
                        rd_addr_q <= {cpu_addr[31:2], 2'b00};
                        state_q   <= RD;
                    end
                end
                RD: begin
                    if (rd_issue && mem_ack) begin
                        rd_data_q <= mem_r_data;
                        state_q   <= RD_DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: vector table, directed corner sequences and a
// randomized run against a program-order memory model.
module tb_dm_store_buffer;

    localparam int DEPTH = 4;
`ifdef DM_STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_dm_r, cpu_dm_w, cpu_stall;
    logic [31:0] cpu_addr, cpu_w_data, cpu_r_data;
    logic        mem_req, mem_we, mem_ack, buf_empty;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;

    int errors = 0;
    int checks = 0;

    logic        slave_en;
    logic [31:0] slave_mem [64];
    logic [31:0] ref_mem [64];

    typedef struct packed {
        logic [29:0] word;
        logic [31:0] data;
    } wr_t;
    wr_t expq [$];

    typedef struct {
        logic        r, w;
        logic [31:0] addr, wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall, e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_empty;
        logic [31:0] e_rdat;
    } vec_t;
    vec_t vt [16];

    dm_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cpu_dm_r(cpu_dm_r), .cpu_dm_w(cpu_dm_w), .cpu_addr(cpu_addr), .cpu_w_data(cpu_w_data),
        .cpu_r_data(cpu_r_data), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_ack(mem_ack), .mem_r_data(mem_r_data), .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Outputs are examined on the falling edge; the memory model answers there too.
    task automatic sample();
        @(negedge clk);
        if (slave_en) begin
            if (mem_req && !mem_we) mem_r_data = slave_mem[mem_addr[7:2]];
            if (mem_req && mem_we && mem_ack) slave_mem[mem_addr[7:2]] = mem_w_data;
        end
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        cpu_dm_r = r; cpu_dm_w = w; cpu_addr = a; cpu_w_data = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        mem_ack = 1'b0;
        mem_r_data = 32'h0;
        adv();
        adv();
        reset = 1'b0;
    endtask

    // Keep the held load going with an always-acking memory until it completes.
    task automatic finish_load(input string name, input logic [31:0] exp);
        for (int n = 0; n < 30 && cpu_stall; n++) begin
            adv();
            mem_ack = 1'b1;
            sample();
            if (mem_req && !mem_we) check({name, ".rd_after_drain"}, buf_empty, 1);
        end
        check({name, ".done"}, cpu_stall, 0);
        check({name, ".data"}, cpu_r_data, exp);
    endtask

    logic [31:0] A [5];
    int          cur_op, hold, qsize, ack_pct;
    bit          pending, in_q;
    logic [29:0] cur_word;
    logic [1:0]  cur_low;
    logic [31:0] cur_data;

    initial begin
        A[0] = 32'hA000_0000; A[1] = 32'hA111_1111; A[2] = 32'hA222_2222;
        A[3] = 32'hA333_3333; A[4] = 32'hA444_4444;
        //        r    w    addr      wdata  ack  rdata          stall req  we   addr      wdata  empty rdat
        vt[0]  = '{1'b0,1'b0,32'h00,32'h0, 1'b0,32'h0,         1'b0,1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0};
        vt[1]  = '{1'b0,1'b1,32'h00,A[0],  1'b0,32'h0,         1'b0,1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0};
        vt[2]  = '{1'b0,1'b1,32'h04,A[1],  1'b0,32'h0,         1'b0,1'b1,1'b1,32'h00,A[0],  1'b0,32'h0};
        vt[3]  = '{1'b0,1'b1,32'h08,A[2],  1'b0,32'h0,         1'b0,1'b1,1'b1,32'h00,A[0],  1'b0,32'h0};
        vt[4]  = '{1'b0,1'b1,32'h0C,A[3],  1'b0,32'h0,         1'b0,1'b1,1'b1,32'h00,A[0],  1'b0,32'h0};
        vt[5]  = '{1'b0,1'b1,32'h10,A[4],  1'b0,32'h0,         1'b1,1'b1,1'b1,32'h00,A[0],  1'b0,32'h0};
        vt[6]  = '{1'b0,1'b1,32'h10,A[4],  1'b1,32'h0,         1'b1,1'b1,1'b1,32'h00,A[0],  1'b0,32'h0};
        vt[7]  = '{1'b0,1'b1,32'h10,A[4],  1'b1,32'h0,         1'b0,1'b1,1'b1,32'h04,A[1],  1'b0,32'h0};
        vt[8]  = '{1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0,         1'b0,1'b1,1'b1,32'h08,A[2],  1'b0,32'h0};
        vt[9]  = '{1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0,         1'b0,1'b1,1'b1,32'h0C,A[3],  1'b0,32'h0};
        vt[10] = '{1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0,         1'b0,1'b1,1'b1,32'h10,A[4],  1'b0,32'h0};
        vt[11] = '{1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0,         1'b0,1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0};
        vt[12] = '{1'b1,1'b0,32'h80,32'h0, 1'b1,32'h1234_5678, 1'b1,1'b0,1'b0,32'h00,32'h0, 1'b1,32'h0};
        vt[13] = '{1'b1,1'b0,32'h80,32'h0, 1'b1,32'h1234_5678, 1'b1,1'b1,1'b0,32'h80,32'h0, 1'b1,32'h0};
        vt[14] = '{1'b1,1'b0,32'h80,32'h0, 1'b1,32'h1234_5678, 1'b0,1'b0,1'b0,32'h00,32'h0, 1'b1,32'h1234_5678};
        vt[15] = '{1'b0,1'b0,32'h00,32'h0, 1'b0,32'h0,         1'b0,1'b0,1'b0,32'h00,32'h0, 1'b1,32'h1234_5678};

        slave_en = 1'b0;
        for (int i = 0; i < 64; i++) slave_mem[i] = 32'h0;
        do_reset();

        // Reset state
        sample();
        check("rst.mem_req", mem_req, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_w_data", mem_w_data, 0);
        check("rst.cpu_stall", cpu_stall, 0);
        check("rst.cpu_r_data", cpu_r_data, 0);
        check("rst.buf_empty", buf_empty, 1);

        // Vector table: FIFO fill/full/drain, then a load miss with an always-acking memory
        for (int i = 0; i < 16; i++) begin
            adv();
            set_cpu(vt[i].r, vt[i].w, vt[i].addr, vt[i].wdata);
            mem_ack = vt[i].ack;
            mem_r_data = vt[i].rdata;
            sample();
            check($sformatf("v%0d.stall", i), cpu_stall, vt[i].e_stall);
            check($sformatf("v%0d.req", i), mem_req, vt[i].e_req);
            if (vt[i].e_req) begin
                check($sformatf("v%0d.we", i), mem_we, vt[i].e_we);
                check($sformatf("v%0d.addr", i), mem_addr, vt[i].e_addr);
            end
            if (vt[i].e_req && vt[i].e_we) check($sformatf("v%0d.wdata", i), mem_w_data, vt[i].e_wdata);
            check($sformatf("v%0d.empty", i), buf_empty, vt[i].e_empty);
            check($sformatf("v%0d.rdata", i), cpu_r_data, vt[i].e_rdat);
        end
        adv();

        // Store then immediately load the same word with the memory not acking
        slave_en = 1'b1;
        do_reset();
        set_cpu(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
        sample();
        check("ld40.st_stall", cpu_stall, 0);
        adv();
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        sample();
        check("ld40.stall0", cpu_stall, !FWD);
        check("ld40.wr_first", {mem_req, mem_we}, 2'b11);
        if (!cpu_stall) check("ld40.fwd_data", cpu_r_data, 32'hDEAD_BEEF);
        for (int n = 0; n < 3 && cpu_stall; n++) begin
            adv();
            sample();
            check("ld40.hold_stall", cpu_stall, 1);
            check("ld40.hold_wr", {mem_req, mem_we, mem_addr}, {2'b11, 32'h40});
        end
        finish_load("ld40", 32'hDEAD_BEEF);
        for (int n = 0; n < 6; n++) begin
            adv();
            set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
            mem_ack = 1'b1;
            sample();
            check("ld40.no_read", mem_req && !mem_we, 0);
        end
        check("ld40.drained", buf_empty, 1);

        // Two stores to one word (second with nonzero byte offset); load must see the younger
        do_reset();
        set_cpu(1'b0, 1'b1, 32'h20, 32'h1);
        sample();
        adv();
        set_cpu(1'b0, 1'b1, 32'h23, 32'h2);
        sample();
        check("young.st2_stall", cpu_stall, 0);
        adv();
        set_cpu(1'b1, 1'b0, 32'h20, 32'h0);
        sample();
        check("young.stall0", cpu_stall, !FWD);
        finish_load("young", 32'h2);
        adv();
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset while a load waits in RD behind a draining store
        do_reset();
        set_cpu(1'b0, 1'b1, 32'h50, 32'h5);
        sample();
        check("rstmid.st_stall", cpu_stall, 0);
        adv();
        set_cpu(1'b1, 1'b0, 32'h60, 32'h0);
        sample();
        check("rstmid.ld_stall", cpu_stall, 1);
        adv();
        sample();
        check("rstmid.pre_req", mem_req, 1);
        check("rstmid.pre_stall", cpu_stall, 1);
        reset = 1'b1;
        adv();
        reset = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        sample();
        check("rstmid.req", mem_req, 0);
        check("rstmid.stall", cpu_stall, 0);
        check("rstmid.empty", buf_empty, 1);
        check("rstmid.rdata", cpu_r_data, 0);
        adv();
        sample();
        check("rstmid.req2", mem_req, 0);

        // Randomized traffic against a program-order memory model
        do_reset();
        for (int i = 0; i < 64; i++) begin
            slave_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        expq.delete();
        pending = 1'b0;
        hold = 0;
        ack_pct = 100;
        cur_op = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 250 == 0) ack_pct = (cyc % 750 == 0) ? 100 : ((cyc % 750 == 250) ? 60 : 25);
            if (!pending) begin
                automatic int k = $urandom_range(9);
                cur_op   = (k < 4) ? 1 : ((k < 7) ? 2 : 0);
                cur_word = 30'($urandom_range(15));
                cur_low  = 2'($urandom_range(3));
                cur_data = $urandom;
                pending  = (cur_op != 0);
                hold     = 0;
            end
            set_cpu(cur_op == 2, cur_op == 1, {cur_word, cur_low}, cur_data);
            mem_ack = ($urandom_range(99) < ack_pct);
            sample();
            qsize = expq.size();
            in_q = 1'b0;
            foreach (expq[j]) if (expq[j].word == cur_word) in_q = 1'b1;
            check("rnd.empty", buf_empty, qsize == 0);
            if (mem_req && mem_we) begin
                check("rnd.wr_pending", qsize != 0, 1);
                if (mem_ack && qsize != 0) begin
                    check("rnd.wr", {mem_addr, mem_w_data}, {expq[0].word, 2'b00, expq[0].data});
                    void'(expq.pop_front());
                end
            end
            if (mem_req && !mem_we) begin
                check("rnd.rd_drained", qsize, 0);
                check("rnd.rd_addr", mem_addr, {cur_word, 2'b00});
            end
            if (cur_op == 1) begin
                check("rnd.st_stall", cpu_stall, qsize == DEPTH);
                if (!cpu_stall) begin
                    expq.push_back('{cur_word, cur_data});
                    ref_mem[cur_word[5:0]] = cur_data;
                    pending = 1'b0;
                end
            end else if (cur_op == 2) begin
                if (hold == 0) check("rnd.ld_stall0", cpu_stall, !(FWD && in_q));
                if (!cpu_stall) begin
                    check("rnd.ld_data", cpu_r_data, ref_mem[cur_word[5:0]]);
                    pending = 1'b0;
                end
            end
            hold++;
            if (pending && hold > 200) begin
                checks++;
                errors++;
                $display("FAIL rnd.timeout: request held %0d cycles, required completion within 200", hold);
                break;
            end
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
